// File: rtl/mp_add_pkg.sv
// rtl/mp_add_pkg.sv - shared word width and sequencer state encoding
package mp_add_pkg;

  localparam int WORD_W = 32;

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_MID   = 1'b1
  } state_t;

endpackage

// File: rtl/csk_add32.sv
// rtl/csk_add32.sv - 32-bit carry-skip adder, 4-bit ripple blocks with block-propagate bypass
module csk_add32
  import mp_add_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  localparam int BLK  = 4;
  localparam int NBLK = WORD_W / BLK;

  always_comb begin
    logic [NBLK:0] bc;
    logic          c;
    logic          p;
    sum   = '0;
    bc    = '0;
    bc[0] = cin;
    for (int k = 0; k < NBLK; k++) begin
      c = bc[k];
      p = 1'b1;
      for (int i = 0; i < BLK; i++) begin
        sum[k*BLK+i] = a[k*BLK+i] ^ b[k*BLK+i] ^ c;
        c = (a[k*BLK+i] & b[k*BLK+i]) | (c & (a[k*BLK+i] ^ b[k*BLK+i]));
        p = p & (a[k*BLK+i] ^ b[k*BLK+i]);
      end
      // A fully propagating block passes its carry-in straight through.
      bc[k+1] = p ? bc[k] : c;
    end
    cout = bc[NBLK];
  end

endmodule

// File: rtl/mp_add_seq.sv
// rtl/mp_add_seq.sv - word-serial multi-precision add sequencer driving an external 32-bit adder
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int MAX_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_a,
  input  logic [WORD_W-1:0] s_b,
  input  logic              s_last,
  input  logic              s_cin,
  output logic [WORD_W-1:0] add_a,
  output logic [WORD_W-1:0] add_b,
  output logic              add_cin,
  input  logic [WORD_W-1:0] add_sum,
  input  logic              add_cout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_sum,
  output logic              m_last,
  output logic              m_cout,
  output logic              m_err
);

  localparam int               CNT_W   = $clog2(MAX_WORDS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS - 1);

  state_t           state;
  state_t           state_nxt;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             term;

  always_comb begin
    s_ready = !m_valid || m_ready;
    accept  = s_valid && s_ready;
    term    = s_last || (cnt == CNT_MAX);
    add_a   = s_a;
    add_b   = s_b;
    // The packet carry-in only enters on the first word; later words chain.
    add_cin = (state == ST_FIRST) ? s_cin : carry_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FIRST;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = term ? ST_FIRST : ST_MID;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_sum   <= '0;
      m_last  <= 1'b0;
      m_cout  <= 1'b0;
      m_err   <= 1'b0;
      carry_q <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      m_valid <= 1'b1;
      m_sum   <= add_sum;
      m_cout  <= add_cout;
      carry_q <= add_cout;
      m_last  <= term;
      m_err   <= term && !s_last;
      cnt     <= term ? '0 : cnt + CNT_W'(1);
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mp_add_seq.sv
// tb/tb_mp_add_seq.sv - self-checking bench for mp_add_seq wired to csk_add32
module tb_mp_add_seq;
  import mp_add_pkg::*;

  localparam int MAXW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_a = '0;
  logic [31:0] s_b = '0;
  logic        s_last = 1'b0;
  logic        s_cin = 1'b0;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_sum;
  logic        m_last;
  logic        m_cout;
  logic        m_err;

  mp_add_seq #(.MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last), .s_cin(s_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .m_valid(m_valid), .m_ready(m_ready), .m_sum(m_sum), .m_last(m_last), .m_cout(m_cout), .m_err(m_err)
  );

  csk_add32 u_add (
    .a(add_a), .b(add_b), .cin(add_cin), .sum(add_sum), .cout(add_cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sum;
    logic        last;
    logic        cout;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        last;
    logic [31:0] sum;
    logic        last_o;
    logic        cout;
    logic        err;
  } vec_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          bp_mode = 1'b0;
  logic [31:0] pa[MAXW];
  logic [31:0] pb[MAXW];
  int          pn = 0;
  logic        pcin = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] sum, input logic last, input logic cout, input logic err);
    exp_t e;
    e.sum = sum; e.last = last; e.cout = cout; e.err = err;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the word is taken.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic last);
    int t;
    s_a = a; s_b = b; s_cin = cin; s_last = last; s_valid = 1'b1;
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (s_ready) break;
    end
    if (t == 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: s_ready=%b, required 1", s_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: the packet is one wide integer sum; each word's result is a slice
  // of the prefix sum, its carry the bit just above that prefix.
  task automatic model_send(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic last);
    logic [MAXW*32:0] wa;
    logic [MAXW*32:0] wb;
    logic [MAXW*32:0] ws;
    int               w;
    if (pn == 0) pcin = cin;
    pa[pn] = a;
    pb[pn] = b;
    w = pn + 1;
    wa = '0;
    wb = '0;
    for (int i = 0; i < w; i++) begin
      wa[i*32 +: 32] = pa[i];
      wb[i*32 +: 32] = pb[i];
    end
    ws = wa + wb + {{(MAXW*32){1'b0}}, pcin};
    push(ws[pn*32 +: 32], last || (w == MAXW), ws[w*32], (w == MAXW) && !last);
    pn = (last || (w == MAXW)) ? 0 : w;
    send(a, b, cin, last);
  endtask

  initial begin : monitor
    logic        stall_q;
    logic [31:0] held_sum;
    logic [3:0]  held_flags;
    exp_t        e;
    stall_q = 1'b0;
    held_sum = '0;
    held_flags = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          check("hold_sum", m_sum, held_sum);
          check("hold_valid_last_cout_err", {m_valid, m_last, m_cout, m_err}, held_flags);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got sum %h, required no output", m_sum);
          end else begin
            e = exp_q.pop_front();
            check("m_sum", m_sum, e.sum);
            check("m_last_cout_err", {m_last, m_cout, m_err}, {e.last, e.cout, e.err});
          end
        end
        stall_q = m_valid && !m_ready;
        held_sum = m_sum;
        held_flags = {1'b1, m_last, m_cout, m_err};
      end
    end
  end

  initial begin : backpressure
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t tbl[9];
    int   t;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_m_valid", m_valid, 0);
    check("reset_s_ready", s_ready, 1);
    check("reset_m_sum", m_sum, 0);
    check("reset_flags", {m_last, m_cout, m_err}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single word, 2-word carry chain, back-to-back packets, MID ignores s_cin
    tbl[0] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0009, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      push(tbl[i].sum, tbl[i].last_o, tbl[i].cout, tbl[i].err);
      send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].last);
    end
    idle(2);

    // backpressure mid-packet: 3 stalled cycles must not disturb the carry
    push(32'h0000_0000, 1'b0, 1'b1, 1'b0);
    push(32'h0000_0000, 1'b0, 1'b1, 1'b0);
    push(32'h0000_000C, 1'b0, 1'b0, 1'b0);
    push(32'h0000_0000, 1'b1, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
    m_ready = 1'b0;
    s_a = 32'h5; s_b = 32'h6; s_cin = 1'b0; s_last = 1'b0; s_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_s_ready", s_ready, 0);
      check("stall_add_cin", add_cin, 1);
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    send(32'h5, 32'h6, 1'b0, 1'b0);
    send(32'h0, 32'h0, 1'b0, 1'b1);
    idle(2);

    // truncation at MAX_WORDS, then the 9th word opens a fresh packet with s_cin=0
    for (int k = 0; k < MAXW; k++) begin
      push(32'h0000_0000, k == MAXW - 1, 1'b1, k == MAXW - 1);
      send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    end
    push(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
    idle(2);

    // reset mid-packet after word 2 of 4
    push(32'h0000_0003, 1'b0, 1'b0, 1'b0);
    push(32'h0000_0007, 1'b0, 1'b0, 1'b0);
    send(32'h1, 32'h2, 1'b0, 1'b0);
    send(32'h3, 32'h4, 1'b0, 1'b0);
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_m_sum", m_sum, 0);
    check("midrst_flags", {m_last, m_cout, m_err}, 0);
    check("midrst_s_ready", s_ready, 1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(32'h0000_0010, 1'b1, 1'b0, 1'b0);
    send(32'h7, 32'h8, 1'b1, 1'b1);
    idle(2);

    // randomized packets with random backpressure and gaps against the wide-integer model
    bp_mode = 1'b1;
    pn = 0;
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 10);
      for (int k = 0; k < len; k++) begin
        logic [31:0] ra;
        logic [31:0] rb;
        ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        rb = ($urandom_range(0, 3) == 0) ? 32'h0000_0000 : $urandom;
        model_send(ra, rb, 1'($urandom_range(0, 1)), k == len - 1);
        if ($urandom_range(0, 4) == 0) idle(1);
      end
    end
    s_valid = 1'b0;
    bp_mode = 1'b0;
    m_ready = 1'b1;

    for (t = 0; t < 200; t++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !m_valid) break;
    end
    check("drain_pending", exp_q.size(), 0);
    check("drain_m_valid", m_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mp_add_seq.md
# mp_add_seq

Word-serial multi-precision add sequencer that sits directly in front of the team's 32-bit carry-skip adder. It accepts LSW-first streams of 32-bit operand word pairs, drives the adder's A/B/Cin, and chains the adder's carry-out into the next word's carry-in. It registers each sum word into a valid/ready output stream, so wide additions (up to MAX_WORDS×32 bits) run at one word per cycle through a single 32-bit adder.

## Interface
- MAX_WORDS, 8, maximum words per packet (2..256); the word counter is $clog2(MAX_WORDS) bits wide.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid && s_ready.
- s_a, s_b  in  32  operand words, LSW first.
- s_last  in  1  final (most significant) word of the packet.
- s_cin  in  1  packet carry-in; sampled only with the first word of a packet.
- add_a, add_b  out  32  to the adder's A/B inputs.
- add_cin  out  1  to the adder's Cin input.
- add_sum  in  32  from the adder's Sum output.
- add_cout  in  1  from the adder's Cout output.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts when m_valid && m_ready.
- m_sum  out  32  sum word.
- m_last  out  1  final word of the packet.
- m_cout  out  1  carry-out of this word; meaningful as the packet carry when m_last=1.
- m_err  out  1  qualified by m_valid && m_last; packet was truncated at MAX_WORDS.

## Operation
- FSM states:
  - FIRST: next accepted word starts a packet.
  - MID: inside a packet.
- Adder drive (combinational):
  - add_a = s_a, add_b = s_b.
  - add_cin = (state==FIRST) ? s_cin : carry_q.
- s_ready = !m_valid || m_ready. This is a one-deep output register with no skid buffer.
- On an accepted word (s_valid && s_ready):
  - m_sum ← add_sum, m_cout ← add_cout, carry_q ← add_cout, m_valid ← 1.
  - term = s_last || (cnt == MAX_WORDS-1).
  - m_last ← term, m_err ← term && !s_last.
  - If term: state ← FIRST, cnt ← 0. Otherwise: state ← MID, cnt ← cnt+1.
- Truncation: if MAX_WORDS words arrive without s_last, the block closes the packet (m_last=1, m_err=1). The next accepted word starts a new packet and uses s_cin.
- On m_valid && m_ready with no accepted input: m_valid ← 0. Simultaneous drain and accept keeps m_valid=1 and loads the new word.
- Packets carry no data between them. carry_q is ignored in FIRST.
- Inputs while !s_ready are not sampled and the adder result is discarded. s_* must be held stable by upstream (standard valid/ready hold rule).

## Timing
- Latency: 1 cycle from input accept to m_valid.
- Throughput: 1 word/cycle while m_ready=1.
- Critical path: s_a/s_b → external adder → m_sum/carry_q registers, within a single cycle. The adder is not registered internally.
- Reset (asynchronous, rst_n low) sets:
  - m_valid=0, m_sum=0, m_last=0, m_cout=0, m_err=0.
  - carry_q=0, cnt=0, state=FIRST.
- s_ready is 1 out of reset.
- Reset mid-packet abandons the packet with no flush and no m_last. The first word after reset starts a new packet.
- Back-to-back packets: the cycle after accepting an s_last word may accept the first word of the next packet. That word uses s_cin with no bubble.
- m_* must remain stable while m_valid && !m_ready.

## Structure
- Shared package mp_add_pkg holds:
  - WORD_W=32.
  - State enum: ST_FIRST, ST_MID.
- Single module, no sub-module. The 32-bit carry-skip adder is instantiated beside mp_add_seq in the parent and wired through add_*. The bench instantiates the real adder the same way.

## Test plan
- Single-word packet: s_a=0x0000_0005, s_b=0x0000_0003, s_cin=1, s_last=1 → next cycle m_sum=0x0000_0009, m_last=1, m_cout=0, m_err=0.
- Carry chain, 2 words: {0x0000_0000,0xFFFF_FFFF}+{0x0000_0000,0x0000_0001}, cin=0 → m_sum=0x0000_0000 with m_cout=1, then m_sum=0x0000_0001, m_last=1, m_cout=0.
- Backpressure: hold m_ready=0 for 3 cycles mid-packet → s_ready=0, m_* frozen, carry preserved; final result identical to the unstalled run.
- Truncation with MAX_WORDS=8: 9 words, no s_last, all-0xFFFF_FFFF + 0 with cin=1 → word 8 has m_last=1, m_err=1. Word 9 restarts with s_cin (m_sum=s_a+s_b+s_cin, carry not chained).
- Back-to-back: packet A ends with carry_q=1; packet B's first word 0+0 with s_cin=0 accepted the next cycle → m_sum=0, proving carry_q is ignored.
- Reset mid-packet: assert rst_n=0 after word 2 of 4 → all outputs 0 immediately. After release, a 1-word packet adds correctly using s_cin.
